mem_access_ctrl: RTL and testbench

Memory access controller that sequences the 13-bit memory address register and the memory strobes on behalf of two requesters: instruction fetch (IF) and data memory (DM). It arbitrates round-robin between them, loads the address into the MAR, then drives the MAR onto the bus. It runs a fixed-length read or write cycle with programmable wait states and returns a one-cycle acknowledge. It sits between the control unit / fetch logic and the MAR, memory and MDR path.

---
 rtl/mem_access_ctrl.sv | 113 +++++++++++
 tb/tb_mem_access_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access controller: round-robin IF/DM arbitration, MAR load/drive, then a read or
// write strobe held WAIT_STATES+1 cycles, then a one-cycle ack. Req-to-ack latency 4+WAIT_STATES.
module mem_access_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              wr_MAR,
  output logic              re_MAR,
  output logic [ADDR_W-1:0] MARin,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, ACCESS, DONE} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t            state, state_nxt;
  logic              gnt_dm;
  logic              last_dm;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wait_cnt;
  logic              grant_vld;
  logic              grant_dm;

  // On contention the requester not served last wins.
  always_comb begin
    grant_vld = if_req | dm_req;
    grant_dm  = dm_req & (~if_req | ~last_dm);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = LOAD;
      LOAD:    state_nxt = ISSUE;
      ISSUE:   state_nxt = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_dm   <= 1'b0;
      last_dm  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= 4'd0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            gnt_dm  <= grant_dm;
            last_dm <= grant_dm;
            we_q    <= grant_dm & dm_we;
            addr_q  <= grant_dm ? dm_addr : if_addr;
            wdata_q <= grant_dm ? dm_wdata : '0;
          end
        end
        ISSUE: wait_cnt <= WS;
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            if (!we_q) begin
              if (gnt_dm) dm_rdata <= mem_rdata;
              else        if_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_MAR    = (state == LOAD);
    re_MAR    = (state == ISSUE);
    MARin     = (state == LOAD) ? addr_q : '0;
    mem_rd    = (state == ACCESS) & ~we_q;
    mem_wr    = (state == ACCESS) & we_q;
    mem_wdata = (state == ACCESS) ? wdata_q : '0;
    if_ack    = (state == DONE) & ~gnt_dm;
    dm_ack    = (state == DONE) & gnt_dm;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: four instances with WAIT_STATES 1, 0, 3, 15 driven by directed
// requests; expected acks are queued at issue time and checked by a negedge monitor.
module tb_mem_access_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] mem_rdata;
  logic        if_req[N];
  logic [12:0] if_addr[N];
  logic        dm_req[N];
  logic        dm_we[N];
  logic [12:0] dm_addr[N];
  logic [15:0] dm_wdata[N];
  logic        if_ack[N];
  logic [15:0] if_rdata[N];
  logic        dm_ack[N];
  logic [15:0] dm_rdata[N];
  logic        wr_MAR[N];
  logic        re_MAR[N];
  logic [12:0] MARin[N];
  logic        mem_rd[N];
  logic        mem_wr[N];
  logic [15:0] mem_wdata[N];
  logic        busy[N];

  function automatic int wsv(int d);
    case (d)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_access_ctrl #(
      .ADDR_W(13), .DATA_W(16),
      .WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 15)
    ) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
      .dm_ack(dm_ack[g]), .dm_rdata(dm_rdata[g]),
      .wr_MAR(wr_MAR[g]), .re_MAR(re_MAR[g]), .MARin(MARin[g]),
      .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata), .busy(busy[g])
    );
  end

  typedef struct {
    int          dut;
    bit          is_dm;
    bit          we;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_if;
    logic [15:0] exp_dm;
    int          ack_cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [15:0] m_if[N];
  logic [15:0] m_dm[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    tests++;
    fails++;
    $display("FAIL %s: event not expected/not seen (cycle %0d)", name, cyc);
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each ack.
  int   slen[N];
  bit   pwr[N], pre[N], pack[N];
  exp_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < N; d++) begin
        if (wr_MAR[d] || re_MAR[d]) check("mar_exclusive", 32'(wr_MAR[d] & re_MAR[d]), 0);
        if (wr_MAR[d]) begin
          check("wr_mar_width", 32'(pwr[d]), 0);
          if (sb.size() == 0) fail_now("wr_mar_unexpected");
          else check("marin", 32'(MARin[d]), 32'(sb[0].addr));
        end else begin
          check("marin_idle", 32'(MARin[d]), 0);
        end
        if (re_MAR[d]) check("re_mar_width", 32'(pre[d]), 0);
        if (mem_rd[d] || mem_wr[d]) begin
          slen[d]++;
          if (sb.size() != 0) begin
            check("strobe_kind", 32'(mem_wr[d]), 32'(sb[0].we));
            if (mem_wr[d]) check("mem_wdata", 32'(mem_wdata[d]), 32'(sb[0].wdata));
          end
        end else begin
          check("mem_wdata_idle", 32'(mem_wdata[d]), 0);
          if (slen[d] != 0) check("strobe_width", 32'(slen[d]), 32'(wsv(d) + 1));
          slen[d] = 0;
        end
        if (if_ack[d] || dm_ack[d]) begin
          check("ack_width", 32'(pack[d]), 0);
          if (sb.size() == 0) fail_now("ack_unexpected");
          else begin
            e = sb.pop_front();
            check("ack_dut", 32'(d), 32'(e.dut));
            check("ack_which", 32'({if_ack[d], dm_ack[d]}), e.is_dm ? 32'h1 : 32'h2);
            check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
            check("if_rdata", 32'(if_rdata[d]), 32'(e.exp_if));
            check("dm_rdata", 32'(dm_rdata[d]), 32'(e.exp_dm));
          end
        end
        pwr[d]  = wr_MAR[d];
        pre[d]  = re_MAR[d];
        pack[d] = if_ack[d] | dm_ack[d];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int d, bit is_dm, bit we, logic [12:0] a, logic [15:0] wd, int ack_cyc);
    exp_t x;
    if (!we) begin
      if (is_dm) m_dm[d] = mem_rdata;
      else       m_if[d] = mem_rdata;
    end
    x.dut = d; x.is_dm = is_dm; x.we = we; x.addr = a; x.wdata = wd;
    x.exp_if = m_if[d]; x.exp_dm = m_dm[d]; x.ack_cyc = ack_cyc;
    sb.push_back(x);
  endtask

  // Holds req until ack, then drops it within the ack cycle.
  task automatic do_req(int d, bit is_dm, bit we, logic [12:0] a, logic [15:0] wd);
    bit got = 1'b0;
    if (is_dm) begin
      dm_req[d] = 1'b1; dm_we[d] = we; dm_addr[d] = a; dm_wdata[d] = wd;
    end else begin
      if_req[d] = 1'b1; if_addr[d] = a;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = is_dm ? dm_ack[d] : if_ack[d];
    end
    if (!got) fail_now("ack_timeout");
    if (is_dm) dm_req[d] = 1'b0;
    else       if_req[d] = 1'b0;
  endtask

  task automatic single(int d, bit is_dm, bit we, logic [12:0] a, logic [15:0] wd);
    push(d, is_dm, we, a, wd, cyc + 4 + wsv(d));
    do_req(d, is_dm, we, a, wd);
    tick();
    tick();
  endtask

  initial begin
    int c;
    bit seen;
    rst = 1'b1;
    mem_rdata = 16'h0000;
    for (int d = 0; d < N; d++) begin
      if_req[d] = 1'b0; if_addr[d] = '0; dm_req[d] = 1'b0; dm_we[d] = 1'b0;
      dm_addr[d] = '0; dm_wdata[d] = '0; m_if[d] = '0; m_dm[d] = '0;
      slen[d] = 0; pwr[d] = 1'b0; pre[d] = 1'b0; pack[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < N; d++) begin
      check("rst_busy", 32'(busy[d]), 0);
      check("rst_acks", 32'({if_ack[d], dm_ack[d]}), 0);
      check("rst_mar", 32'({wr_MAR[d], re_MAR[d], MARin[d]}), 0);
      check("rst_strobes", 32'({mem_rd[d], mem_wr[d], mem_wdata[d]}), 0);
      check("rst_rdata", {if_rdata[d], dm_rdata[d]}, 0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    mem_rdata = 16'hA5A5; single(0, 1'b0, 1'b0, 13'h0100, 16'h0000);
    single(1, 1'b1, 1'b1, 13'h1FFF, 16'h1234);
    mem_rdata = 16'h3C3C; single(1, 1'b0, 1'b0, 13'h0042, 16'h0000);
    mem_rdata = 16'hBEEF; single(2, 1'b1, 1'b0, 13'h0ABC, 16'h0000);
    mem_rdata = 16'h7E57; single(3, 1'b0, 1'b0, 13'h1000, 16'h0000);
    single(0, 1'b1, 1'b1, 13'h0010, 16'hCAFE);

    // Reset on the second ACCESS cycle of a DM read on the W=1 instance.
    mon_en = 1'b0;
    mem_rdata = 16'h5A5A;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 13'h0777;
    repeat (4) tick();
    check("pre_rst_mem_rd", 32'(mem_rd[0]), 1);
    rst = 1'b1;
    tick();
    dm_req[0] = 1'b0;
    rst = 1'b0;
    check("post_rst_busy", 32'(busy[0]), 0);
    check("post_rst_strobes", 32'({mem_rd[0], mem_wr[0]}), 0);
    seen = dm_ack[0];
    for (int d = 0; d < N; d++) begin m_if[d] = '0; m_dm[d] = '0; end
    for (int i = 0; i < 10; i++) begin tick(); seen |= dm_ack[0]; end
    check("no_dm_ack_after_rst", 32'(seen), 0);
    check("post_rst_dm_rdata", 32'(dm_rdata[0]), 0);
    mon_en = 1'b1;

    // Contention: DM first after reset, then alternating.
    mem_rdata = 16'hC3C3;
    c = cyc;
    push(0, 1'b1, 1'b0, 13'h1555, 16'h0000, c + 5);
    push(0, 1'b0, 1'b0, 13'h0AAA, 16'h0000, c + 11);
    push(0, 1'b1, 1'b0, 13'h1555, 16'h0000, c + 17);
    push(0, 1'b0, 1'b0, 13'h0AAA, 16'h0000, c + 23);
    fork
      begin
        do_req(0, 1'b1, 1'b0, 13'h1555, 16'h0000);
        tick(); tick();
        do_req(0, 1'b1, 1'b0, 13'h1555, 16'h0000);
      end
      begin
        do_req(0, 1'b0, 1'b0, 13'h0AAA, 16'h0000);
        tick(); tick();
        do_req(0, 1'b0, 1'b0, 13'h0AAA, 16'h0000);
      end
    join
    repeat (5) tick();
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
